// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-convolution job scheduler: packet header
// layout, filter/ifmap encodings, FSM state type and packet-width helpers.
package snn_pkg;

  localparam int HDR_W        = 9;
  localparam int HDR_DIR_LSB  = 0;
  localparam int HDR_DIR_W    = 2;
  localparam int HDR_XHOP_LSB = 2;
  localparam int HDR_XHOP_W   = 2;
  localparam int HDR_YHOP_BIT = 4;
  localparam int HDR_TS_BIT   = 5;
  localparam int HDR_FILT_BIT = 6;
  localparam int HDR_ROW_LSB  = 7;
  localparam int HDR_ROW_W    = 2;

  localparam int RES_SPIKE_BIT = 9;
  localparam int RES_PE_LSB    = 10;

  localparam logic       FILT_FLAG = 1'b1;
  localparam logic       IFM_FLAG  = 1'b0;
  localparam logic [1:0] ROW_IFMAP = 2'b00;
  localparam logic [1:0] ROW_0     = 2'b01;
  localparam logic [1:0] ROW_1     = 2'b10;
  localparam logic [1:0] ROW_2     = 2'b11;

  typedef enum logic [2:0] {IDLE, FILT, IFM, WAIT, DONE} state_t;

  function automatic int pkt_width(input int fw);
    return 3 * fw + HDR_W;
  endfunction

  function automatic int spike_width(input int npe, input int nts);
    return npe * nts;
  endfunction

endpackage

// File: rtl/snn_pkt_builder.sv
// Combinational packer: routing header plus either one filter row (three
// weights) or one timestep of the 3x3 binary ifmap.
module snn_pkt_builder
  import snn_pkg::*;
#(
  parameter int         FILTER_WIDTH = 8,
  parameter logic [1:0] DIR          = 2'b11,
  parameter logic [1:0] XHOP         = 2'b10,
  parameter logic       YHOP         = 1'b0
) (
  input  logic                                is_filter,
  input  logic [1:0]                          row,
  input  logic                                ts,
  input  logic [9*FILTER_WIDTH-1:0]           filter,
  input  logic [8:0]                          ifmap_ts,
  output logic [pkt_width(FILTER_WIDTH)-1:0]  pkt
);

  localparam int FW = FILTER_WIDTH;
  localparam int PW = pkt_width(FILTER_WIDTH);

  always_comb begin
    pkt = '0;
    pkt[HDR_DIR_LSB +: HDR_DIR_W]   = DIR;
    pkt[HDR_XHOP_LSB +: HDR_XHOP_W] = XHOP;
    pkt[HDR_YHOP_BIT]               = YHOP;
    if (is_filter) begin
      pkt[HDR_FILT_BIT] = FILT_FLAG;
      // f0 sits in the MSBs of filter, so each row is one contiguous slice
      case (row)
        2'd0: begin
          pkt[HDR_ROW_LSB +: HDR_ROW_W] = ROW_0;
          pkt[PW-1:HDR_W] = filter[9*FW-1 -: 3*FW];
        end
        2'd1: begin
          pkt[HDR_ROW_LSB +: HDR_ROW_W] = ROW_1;
          pkt[PW-1:HDR_W] = filter[6*FW-1 -: 3*FW];
        end
        default: begin
          pkt[HDR_ROW_LSB +: HDR_ROW_W] = ROW_2;
          pkt[PW-1:HDR_W] = filter[3*FW-1 -: 3*FW];
        end
      endcase
    end else begin
      pkt[HDR_FILT_BIT] = IFM_FLAG;
      pkt[HDR_ROW_LSB +: HDR_ROW_W] = ROW_IFMAP;
      pkt[HDR_TS_BIT] = ts;
      // each ifmap row is sent column-reversed: i2,i1,i0 | i5,i4,i3 | i8,i7,i6
      for (int g = 0; g < 3; g++) begin
        for (int j = 0; j < 3; j++) begin
          pkt[HDR_W + 3*g + j] = ifmap_ts[3*g + 2 - j];
        end
      end
    end
  end

endmodule

// File: rtl/snn_conv_scheduler.sv
// Sequences one 3x3 spiking-convolution job into the NoC: three filter rows,
// then per timestep one ifmap packet followed by a wait for all PE results.
module snn_conv_scheduler
  import snn_pkg::*;
#(
  parameter int         FILTER_WIDTH = 8,
  parameter int         OUTPUT_WIDTH = 12,
  parameter int         NUM_PE       = 3,
  parameter int         NUM_TS       = 2,
  parameter logic [1:0] DIR          = 2'b11,
  parameter logic [1:0] XHOP         = 2'b10,
  parameter logic       YHOP         = 1'b0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [9*FILTER_WIDTH-1:0]              filter_i,
  input  logic [9*NUM_TS-1:0]                    ifmap_i,
  output logic                                   pkt_valid,
  input  logic                                   pkt_ready,
  output logic [pkt_width(FILTER_WIDTH)-1:0]     pkt_data,
  input  logic                                   res_valid,
  output logic                                   res_ready,
  input  logic [pkt_width(FILTER_WIDTH)-1:0]     res_data,
  output logic [spike_width(NUM_PE,NUM_TS)-1:0]  spike_map,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err
);

  localparam int         PW       = pkt_width(FILTER_WIDTH);
  localparam int         SW       = spike_width(NUM_PE, NUM_TS);
  localparam logic [2:0] NUM_PE_L = 3'(NUM_PE);
  localparam logic [3:0] PE_MASK  = 4'((1 << NUM_PE) - 1);
  localparam logic       LAST_T   = 1'(NUM_TS - 1);

  state_t                    state_reg, state_next;
  logic [1:0]                row_reg, row_next;
  logic                      t_reg, t_next;
  logic [3:0]                seen_reg, seen_after;
  logic [SW-1:0]             spike_reg, spike_hit;
  logic                      err_reg;
  logic [9*FILTER_WIDTH-1:0] filter_reg, filter_src;
  logic [9*NUM_TS-1:0]       ifmap_reg, ifmap_src;
  logic [8:0]                ifmap_ts;
  logic [PW-1:0]             pkt_built, pkt_data_reg;
  logic                      pkt_valid_reg, res_ready_reg, busy_reg, done_reg;

  logic       start_accept, pkt_fire, res_fire, res_accept;
  logic       pe_bad, pe_dup, all_seen, res_spike;
  logic [1:0] res_pe;
  logic [3:0] spike_idx;
  logic       unused_res_bits;

  assign start_accept = start && (state_reg == IDLE);
  assign pkt_fire     = pkt_valid_reg && pkt_ready;
  assign res_fire     = res_valid && res_ready_reg;
  assign res_pe       = res_data[RES_PE_LSB +: 2];
  assign res_spike    = res_data[RES_SPIKE_BIT];
  assign pe_bad       = {1'b0, res_pe} >= NUM_PE_L;
  assign pe_dup       = seen_reg[res_pe];
  assign res_accept   = res_fire && !pe_bad && !pe_dup;
  assign seen_after   = seen_reg | (res_accept ? (4'b0001 << res_pe) : 4'b0000);
  assign all_seen     = res_accept && ((seen_after & PE_MASK) == PE_MASK);
  assign spike_idx    = (t_reg ? 4'(NUM_PE) : 4'd0) + {2'b00, res_pe};

  // residue and routing fields of results are intentionally dropped
  assign unused_res_bits = ^{res_data[PW-1 -: OUTPUT_WIDTH], res_data[PW-1:12], res_data[8:0]};

  // the first row goes out the cycle after start, before the latches update
  assign filter_src = (state_reg == IDLE) ? filter_i : filter_reg;
  assign ifmap_src  = (state_reg == IDLE) ? ifmap_i  : ifmap_reg;

  generate
    if (NUM_TS > 1) begin : g_ts2
      assign ifmap_ts = t_next ? ifmap_src[17:9] : ifmap_src[8:0];
    end else begin : g_ts1
      assign ifmap_ts = ifmap_src[8:0];
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < SW; gi++) begin : g_spike
      assign spike_hit[gi] = res_accept && (spike_idx == 4'(gi));
    end
  endgenerate

  snn_pkt_builder #(
    .FILTER_WIDTH (FILTER_WIDTH),
    .DIR          (DIR),
    .XHOP         (XHOP),
    .YHOP         (YHOP)
  ) u_builder (
    .is_filter (state_next == FILT),
    .row       (row_next),
    .ts        (t_next),
    .filter    (filter_src),
    .ifmap_ts  (ifmap_ts),
    .pkt       (pkt_built)
  );

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    t_next     = t_reg;
    case (state_reg)
      IDLE: if (start) begin
        state_next = FILT;
        row_next   = 2'd0;
        t_next     = 1'b0;
      end
      FILT: if (pkt_fire) begin
        if (row_reg == 2'd2) begin
          state_next = IFM;
          t_next     = 1'b0;
        end else begin
          row_next = row_reg + 2'd1;
        end
      end
      IFM: if (pkt_fire) state_next = WAIT;
      WAIT: if (all_seen) begin
        if (t_reg == LAST_T) begin
          state_next = DONE;
        end else begin
          t_next     = t_reg + 1'b1;
          state_next = IFM;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // outputs are decoded from the next state so they line up with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      row_reg       <= 2'd0;
      t_reg         <= 1'b0;
      seen_reg      <= '0;
      spike_reg     <= '0;
      err_reg       <= 1'b0;
      filter_reg    <= '0;
      ifmap_reg     <= '0;
      pkt_valid_reg <= 1'b0;
      pkt_data_reg  <= '0;
      res_ready_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      row_reg       <= row_next;
      t_reg         <= t_next;
      seen_reg      <= (state_reg == WAIT) ? seen_after : 4'b0000;
      if (start_accept) begin
        filter_reg <= filter_i;
        ifmap_reg  <= ifmap_i;
        spike_reg  <= '0;
        err_reg    <= 1'b0;
      end else begin
        spike_reg <= (spike_reg & ~spike_hit) | (spike_hit & {SW{res_spike}});
        if (res_fire && (pe_bad || pe_dup)) err_reg <= 1'b1;
      end
      pkt_valid_reg <= (state_next == FILT) || (state_next == IFM);
      pkt_data_reg  <= ((state_next == FILT) || (state_next == IFM)) ? pkt_built : '0;
      res_ready_reg <= (state_next == WAIT);
      busy_reg      <= (state_next != IDLE);
      done_reg      <= (state_next == DONE);
    end
  end

  assign pkt_valid = pkt_valid_reg;
  assign pkt_data  = pkt_data_reg;
  assign res_ready = res_ready_reg;
  assign spike_map = spike_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_snn_conv_scheduler.sv
// Self-checking bench: packet/result model built from the packet format rules,
// compared against the scheduler every cycle under directed and random jobs.
module tb_snn_conv_scheduler;

  localparam int FW  = 8;
  localparam int NPE = 3;
  localparam int NTS = 2;
  localparam int PW  = 3*FW + 9;
  localparam int SW  = NPE*NTS;
  localparam logic [1:0] DIRV = 2'b11;
  localparam logic [1:0] XH   = 2'b10;
  localparam logic       YH   = 1'b0;

  localparam logic [9*FW-1:0] FIL0 = {8'd5, 8'd5, 8'd5, 8'd5, 8'd4, 8'd3, 8'd0, 8'd2, 8'd5};
  localparam logic [9*NTS-1:0] IFM0 = {9'b000111100, 9'b111000111};

  logic clk, rst, start;
  logic [9*FW-1:0] filter_i;
  logic [9*NTS-1:0] ifmap_i;
  logic pkt_valid, pkt_ready, res_valid, res_ready, busy, done, err;
  logic [PW-1:0] pkt_data, res_data;
  logic [SW-1:0] spike_map;

  snn_conv_scheduler #(
    .FILTER_WIDTH(FW), .OUTPUT_WIDTH(12), .NUM_PE(NPE), .NUM_TS(NTS),
    .DIR(DIRV), .XHOP(XH), .YHOP(YH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .filter_i(filter_i), .ifmap_i(ifmap_i),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .spike_map(spike_map), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [PW-1:0] mk_row(input logic [9*FW-1:0] f, input int r);
    logic [FW-1:0] w [9];
    for (int k = 0; k < 9; k++) w[k] = f[(8-k)*FW +: FW];
    return {w[3*r], w[3*r+1], w[3*r+2], 2'(r+1), 1'b1, 1'b0, YH, XH, DIRV};
  endfunction

  function automatic logic [PW-1:0] mk_ifm(input logic [9*NTS-1:0] m, input int t);
    int ord [9] = '{2, 1, 0, 5, 4, 3, 8, 7, 6};
    logic [PW-1:0] p;
    p = '0;
    for (int j = 0; j < 9; j++) p[9+j] = m[9*t + ord[j]];
    p[8:0] = {2'b00, 1'b0, 1'(t), YH, XH, DIRV};
    return p;
  endfunction

  logic [PW-1:0] exp_q [$];
  int            kind_q [$];
  bit            m_wait, m_busy, m_done, m_err;
  bit            m_seen [4];
  logic [SW-1:0] m_spike;
  int            m_t;
  int            done_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete(); kind_q.delete();
      m_wait = 0; m_busy = 0; m_done = 0; m_err = 0; m_spike = '0; m_t = 0;
      chk("reset_outputs", {pkt_valid, res_ready, busy, done, err, spike_map, pkt_data}, 64'd0);
    end else begin
      bit was_done;
      int kind, pe;
      chk("pkt_valid", pkt_valid, (exp_q.size() > 0) && !m_wait);
      if (pkt_valid && exp_q.size() > 0) chk("pkt_data", pkt_data, exp_q[0]);
      chk("res_ready", res_ready, m_wait);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("spike_map", spike_map, m_spike);
      if (done) done_cnt++;

      was_done = m_done;
      m_done = 0;
      if (start && !m_busy) begin
        for (int r = 0; r < 3; r++) begin exp_q.push_back(mk_row(filter_i, r)); kind_q.push_back(-1); end
        for (int t = 0; t < NTS; t++) begin exp_q.push_back(mk_ifm(ifmap_i, t)); kind_q.push_back(t); end
        m_busy = 1; m_spike = '0; m_err = 0;
      end
      if (was_done) m_busy = 0;
      if (pkt_valid && pkt_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        kind = kind_q.pop_front();
        if (kind >= 0) begin
          m_wait = 1; m_t = kind;
          for (int i = 0; i < 4; i++) m_seen[i] = 0;
        end
      end
      if (res_valid && res_ready) begin
        pe = int'(res_data[11:10]);
        if (pe >= NPE || m_seen[pe]) begin
          m_err = 1;
        end else begin
          m_seen[pe] = 1;
          m_spike[m_t*NPE + pe] = res_data[9];
          if (m_seen[0] && m_seen[1] && m_seen[2]) begin
            m_wait = 0;
            if (m_t == NTS-1) m_done = 1;
          end
        end
      end
    end
  end

  // ---------------- router backpressure ----------------
  int ready_mode = 0;
  int stall_total = 0;
  initial begin
    int sc;
    sc = 0;
    pkt_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_mode != 2) sc = 0;
      case (ready_mode)
        0: pkt_ready = 1'b1;
        1: pkt_ready = ($urandom_range(0, 9) < 7);
        default: begin
          if (pkt_valid && pkt_data[6] && pkt_data[8:7] == 2'b10 && sc < 4) begin
            pkt_ready = 1'b0; sc++; stall_total++;
          end else begin
            pkt_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_rr(output bit ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (res_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL res_ready_timeout: got 0 expected 1");
    end
  endtask

  task automatic send_res(input int pe, input logic sp);
    res_data = PW'({$urandom(), $urandom()});
    res_data[11:10] = 2'(pe);
    res_data[9] = sp;
    res_valid = 1'b1;
    @(posedge clk); #1;
    res_valid = 1'b0;
  endtask

  task automatic run_job(input logic [9*FW-1:0] fil, input logic [9*NTS-1:0] ifm,
                         input int rmode, input int emode,
                         input logic [NPE-1:0] sp0, input logic [NPE-1:0] sp1,
                         input int ord, input int abort_ts);
    bit ok;
    int p [3];
    int k, tmp;
    logic [NPE-1:0] sp;
    ready_mode = rmode;
    filter_i = fil; ifmap_i = ifm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < NTS; t++) begin
      wait_rr(ok);
      if (!ok) return;
      if (t == abort_ts) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      if (t == 0 && rmode == 1) begin
        start = 1'b1; filter_i = ~fil; ifmap_i = ~ifm;
        @(posedge clk); #1;
        start = 1'b0; filter_i = fil; ifmap_i = ifm;
      end
      p = '{0, 1, 2};
      if (t == 0 && ord == 1) p = '{2, 0, 1};
      else if (t == 0 && ord == 2) p = '{1, 0, 2};
      else if (ord == 0) begin
        for (int i = 2; i > 0; i--) begin
          k = $urandom_range(0, i); tmp = p[i]; p[i] = p[k]; p[k] = tmp;
        end
      end
      sp = (t == 0) ? sp0 : sp1;
      for (int i = 0; i < 3; i++) begin
        send_res(p[i], sp[p[i]]);
        if (t == 0 && i == 0 && emode == 1) send_res(p[0], ~sp[p[0]]);
        if (t == 0 && i == 0 && emode == 2) send_res(3, 1'b1);
      end
    end
    for (int i = 0; i < 60 && busy; i++) begin @(posedge clk); #1; end
    chk("job_end_busy", busy, 1'b0);
  endtask

  initial begin
    logic [PW-1:0] pkt;
    logic [8:0] slice;
    int d0, s0;
    rst = 1'b1; start = 1'b0; filter_i = '0; ifmap_i = '0; res_valid = 1'b0; res_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    pkt = mk_row(FIL0, 0);
    chk("model_row0", pkt, {8'd5, 8'd5, 8'd5, 9'b0_1100_1011});
    pkt = mk_row(FIL0, 2);
    chk("model_row2", pkt, {8'd0, 8'd2, 8'd5, 9'b1_1100_1011});
    pkt = mk_ifm(IFM0, 0);
    slice = pkt[17:9];
    chk("model_ifm_t0", slice, 9'b111000111);
    pkt = mk_ifm(IFM0, 1);
    slice = pkt[17:9];
    chk("model_ifm_t1", slice, 9'b000111001);
    slice = pkt[8:0];
    chk("model_ifm_t1_hdr", slice, 9'b000101011);

    d0 = done_cnt; s0 = stall_total;
    run_job(FIL0, IFM0, 2, 0, 3'b110, 3'b111, 1, 99);
    chk("tp_spike_map", spike_map, 6'b111110);
    chk("tp_done_once", done_cnt - d0, 1);
    chk("tp_stall_cycles", stall_total - s0, 4);
    chk("tp_err_clear", err, 1'b0);

    run_job(FIL0, IFM0, 0, 1, 3'b010, 3'b101, 2, 99);
    chk("dup_err", err, 1'b1);
    chk("dup_spike_map", spike_map, 6'b101010);

    run_job(FIL0, IFM0, 0, 2, 3'b001, 3'b100, 0, 99);
    chk("badpe_err", err, 1'b1);
    chk("badpe_spike_map", spike_map, 6'b100001);

    run_job(FIL0, IFM0, 1, 0, 3'b111, 3'b000, 0, 1);
    @(negedge clk);
    chk("abort_outputs", {pkt_valid, res_ready, busy, done, err, spike_map}, 11'd0);
    @(posedge clk); #1;
    run_job(FIL0, IFM0, 0, 0, 3'b101, 3'b011, 0, 99);
    chk("replay_spike_map", spike_map, 6'b011101);

    for (int j = 0; j < 20; j++) begin
      run_job((9*FW)'({$urandom(), $urandom(), $urandom()}), (9*NTS)'($urandom()),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
              3'($urandom()), 3'($urandom()), 0, 99);
      repeat (int'($urandom_range(0, 3))) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
